divu_seq_ctrl: RTL and testbench

- Sequencer that wraps the 32-iteration unsigned restoring divider core and turns it into a full RV32M divide unit (DIV, DIVU, REM, REMU).
- Accepts one request at a time over a valid/ready handshake and pulses the core's reset to start it.
- Converts signed operands to magnitudes, counts the core's fixed latency, then applies sign correction and the RISC-V special cases.
- Sits between decode/issue and writeback in the execute stage.

---
 rtl/divu_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_divu_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divu_seq_ctrl.sv
// RV32M divide sequencer: wraps a 32-iteration unsigned restoring divider core,
// handling operand signs, RISC-V divide special cases, and the request/response handshake.
module divu_seq_ctrl #(
  parameter int CORE_LAT = 33,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic             div_reset,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  input  logic [31:0]      div_q,
  input  logic [31:0]      div_r
);

  // Handshakes: a request transfers on a clock edge where req_valid && req_ready;
  // a response transfers on an edge where resp_valid && resp_ready (unless flush).
  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_RESP} state_t;

  localparam int CNT_W = $clog2(CORE_LAT + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               want_rem_q, want_rem_d;
  logic               sign_q_q, sign_q_d;
  logic               sign_r_q, sign_r_d;
  logic [31:0]        div_a_q, div_a_d;
  logic [31:0]        div_b_q, div_b_d;
  logic [31:0]        resp_data_q, resp_data_d;
  logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;
  logic               resp_valid_q, resp_valid_d;
  logic               div_reset_q, div_reset_d;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;

  assign signed_op = ~req_op[0];
  assign a_neg     = signed_op & req_a[31];
  assign b_neg     = signed_op & req_b[31];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    want_rem_d  = want_rem_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    resp_data_d = resp_data_q;
    resp_tag_d  = resp_tag_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          want_rem_d = req_op[1];
          sign_q_d   = signed_op & (req_a[31] ^ req_b[31]);
          sign_r_d   = a_neg;
          div_a_d    = a_neg ? (32'd0 - req_a) : req_a;
          div_b_d    = b_neg ? (32'd0 - req_b) : req_b;
          resp_tag_d = req_tag;
          if (req_b == 32'd0) begin
            state_d     = S_RESP;
            resp_data_d = req_op[1] ? req_a : 32'hFFFF_FFFF;
          end else if (signed_op && req_a == 32'h8000_0000 && req_b == 32'hFFFF_FFFF) begin
            state_d     = S_RESP;
            resp_data_d = req_op[1] ? 32'd0 : 32'h8000_0000;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // Core needs CORE_LAT edges after its reset drops; capture on the edge after that.
        if (cnt_q == CNT_W'(CORE_LAT)) begin
          state_d     = S_RESP;
          resp_data_d = want_rem_q ? (sign_r_q ? (32'd0 - div_r) : div_r)
                                   : (sign_q_q ? (32'd0 - div_q) : div_q);
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush && state_q != S_IDLE) state_d = S_IDLE;

    resp_valid_d = (state_d == S_RESP);
    div_reset_d  = (state_d != S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      want_rem_q   <= 1'b0;
      sign_q_q     <= 1'b0;
      sign_r_q     <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      resp_valid_q <= 1'b0;
      div_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      want_rem_q   <= want_rem_d;
      sign_q_q     <= sign_q_d;
      sign_r_q     <= sign_r_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      resp_valid_q <= resp_valid_d;
      div_reset_q  <= div_reset_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;
  assign div_reset  = div_reset_q;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;

endmodule

// File: tb/tb_divu_seq_ctrl.sv
// Bench for divu_seq_ctrl: a latency-accurate divider core model plus an
// arithmetic reference for RV32M DIV/DIVU/REM/REMU results.
module tb_divu_seq_ctrl;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;
  logic             div_reset;
  logic [31:0]      div_a;
  logic [31:0]      div_b;
  logic [31:0]      div_q;
  logic [31:0]      div_r;

  divu_seq_ctrl #(.CORE_LAT(33), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .busy(busy), .div_reset(div_reset),
    .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Core model: outputs are junk until 33 edges have passed with its reset low.
  int core_cnt;
  always @(posedge clk) begin
    if (div_reset) core_cnt <= 0;
    else if (core_cnt < 33) core_cnt <= core_cnt + 1;
  end
  assign div_q = (core_cnt >= 33 && div_b != 0) ? div_a / div_b : 32'hDEAD_BEEF;
  assign div_r = (core_cnt >= 33 && div_b != 0) ? div_a % div_b : 32'hBADC_0DE5;

  bit dr_low_seen;
  int rv_seen;
  always @(negedge clk) begin
    if (!div_reset) dr_low_seen = 1'b1;
    if (resp_valid) rv_seen++;
  end

  // scoreboard
  logic [31:0]      exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  int               exp_lat_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    bit sg;
    bit rem;
    sg  = !op[0];
    rem = op[1];
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
    if (sg) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? a % b : a / b;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 35;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // driver: waits for req_ready, presents the request for one accepting edge
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input bit track);
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (track) begin
      exp_q.push_back(ref_result(op, a, b));
      exp_tag_q.push_back(tag);
      exp_lat_q.push_back(ref_latency(op, a, b));
    end
  endtask

  // call right after the accepting edge; checks latency, data and tag
  task automatic wait_resp();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!resp_valid && n < 100);
    check("resp_latency", 32'(n), 32'(exp_lat_q.pop_front()));
    check("resp_data", resp_data, exp_q.pop_front());
    check("resp_tag", 32'(resp_tag), 32'(exp_tag_q.pop_front()));
  endtask

  task automatic release_resp(input int hold);
    logic [31:0] d;
    d = resp_data;
    repeat (hold) begin
      @(negedge clk);
      check("hold_data", resp_data, d);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("resp_valid_after_handshake", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0]      hd;
    logic [TAG_W-1:0] ht;
    logic [1:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    int               mode;

    reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_a = '0; req_b = '0;
    req_tag = '0; flush = 1'b0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_tag", 32'(resp_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_div_reset", 32'(div_reset), 32'd1);
    check("rst_div_a", div_a, 32'd0);
    check("rst_div_b", div_b, 32'd0);
    reset = 1'b0;

    // DIVU 100/7
    send(2'b01, 32'd100, 32'd7, 5'd3, 1'b1);
    wait_resp();
    release_resp(0);

    // REM and DIV of -7 by 2
    send(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1);
    check("div_a_magnitude", div_a, 32'd7);
    check("div_b_magnitude", div_b, 32'd2);
    wait_resp();
    release_resp(1);
    send(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1);
    wait_resp();
    release_resp(0);

    // divide by zero, core never started
    dr_low_seen = 1'b0;
    send(2'b01, 32'd5, 32'd0, 5'd6, 1'b1);
    wait_resp();
    release_resp(0);
    send(2'b11, 32'd5, 32'd0, 5'd7, 1'b1);
    wait_resp();
    release_resp(0);
    check("divzero_core_not_started", 32'(dr_low_seen), 32'd0);

    // signed overflow
    dr_low_seen = 1'b0;
    send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1);
    wait_resp();
    release_resp(0);
    send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1);
    wait_resp();
    release_resp(0);
    check("overflow_core_not_started", 32'(dr_low_seen), 32'd0);

    // backpressure, then release with a request already waiting
    send(2'b01, 32'd1000, 32'd10, 5'd10, 1'b1);
    wait_resp();
    hd = resp_data;
    ht = resp_tag;
    repeat (10) begin
      @(negedge clk);
      check("bp_data", resp_data, hd);
      check("bp_tag", 32'(resp_tag), 32'(ht));
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    req_op = 2'b11; req_a = 32'd1001; req_b = 32'd10; req_tag = 5'd11; req_valid = 1'b1;
    exp_q.push_back(ref_result(2'b11, 32'd1001, 32'd10));
    exp_tag_q.push_back(5'd11);
    exp_lat_q.push_back(35);
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("bp_next_accepted", 32'(busy), 32'd1);
    wait_resp();
    release_resp(0);

    // flush during RUN
    send(2'b01, 32'd77, 32'd5, 5'd12, 1'b0);
    repeat (12) @(negedge clk);
    check("run_busy", 32'(busy), 32'd1);
    check("run_core_released", 32'(div_reset), 32'd0);
    rv_seen = 0;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_div_reset", 32'(div_reset), 32'd1);
    repeat (40) @(negedge clk);
    check("flush_no_resp", 32'(rv_seen), 32'd0);

    // async reset during RUN
    send(2'b00, 32'd123, 32'd4, 5'd13, 1'b0);
    repeat (15) @(negedge clk);
    rv_seen = 0;
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_div_reset", 32'(div_reset), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("arst_no_resp", 32'(rv_seen), 32'd0);

    // DIVU 9/3 with a coincident flush in IDLE, which must be ignored
    @(negedge clk);
    flush = 1'b1;
    req_op = 2'b01; req_a = 32'd9; req_b = 32'd3; req_tag = 5'd14; req_valid = 1'b1;
    exp_q.push_back(32'd3);
    exp_tag_q.push_back(5'd14);
    exp_lat_q.push_back(35);
    @(posedge clk);
    #1 req_valid = 1'b0;
    flush = 1'b0;
    check("idle_flush_ignored", 32'(busy), 32'd1);
    wait_resp();
    release_resp(0);

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 9);
      op   = 2'($urandom_range(0, 3));
      a    = $urandom;
      b    = (mode < 5) ? $urandom : 32'($urandom_range(1, 300));
      if (mode == 7) b = 32'd0;
      if (mode == 8) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if (mode == 9) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      send(op, a, b, 5'($urandom_range(0, 31)), 1'b1);
      wait_resp();
      release_resp($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
